// File: rtl/mul_issue_ctrl_if.sv
// Execute-stage, consumer and multiplier-side signals of the multiply issue controller.
// slave is the controller's view; master is the surrounding environment's view.
interface mul_issue_ctrl_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [1:0]  in_op_i;
    logic        in_w_i;
    logic [63:0] in_a_i;
    logic [63:0] in_b_i;
    logic        kill_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] out_data_o;
    logic        mul_req_valid_o;
    logic        mul_block_o;
    logic [63:0] mul_op_1_o;
    logic [63:0] mul_op_2_o;
    logic        mul_sign_1_o;
    logic        mul_sign_2_o;
    logic        mul_ready_i;
    logic        mul_valid_i;
    logic [63:0] mul_res_l_i;
    logic [63:0] mul_res_h_i;

    modport slave (
        input  in_valid_i, in_op_i, in_w_i, in_a_i, in_b_i, kill_i, out_ready_i,
               mul_ready_i, mul_valid_i, mul_res_l_i, mul_res_h_i,
        output in_ready_o, out_valid_o, out_data_o, mul_req_valid_o, mul_block_o,
               mul_op_1_o, mul_op_2_o, mul_sign_1_o, mul_sign_2_o
    );

    modport master (
        output in_valid_i, in_op_i, in_w_i, in_a_i, in_b_i, kill_i, out_ready_i,
               mul_ready_i, mul_valid_i, mul_res_l_i, mul_res_h_i,
        input  in_ready_o, out_valid_o, out_data_o, mul_req_valid_o, mul_block_o,
               mul_op_1_o, mul_op_2_o, mul_sign_1_o, mul_sign_2_o
    );
endinterface

// File: rtl/mul_issue_ctrl.sv
// Issue/latency/result controller in front of the fixed-latency Booth/CSA multiplier.
// Define MUL_W_EN to enable MULW (32-bit word multiply with sign-extended result).
module mul_issue_ctrl #(
    parameter int LAT   = 9,
    parameter int CNT_W = 4
) (
    input logic             clk,
    input logic             rst,
    mul_issue_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LAT);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         op_q;
    logic               w_q;
    logic signed [63:0] op_1_q;
    logic signed [63:0] op_2_q;
    logic               sign_1_q;
    logic               sign_2_q;
    logic               req_q;
    logic               out_valid_q;
    logic [63:0]        out_data_q;
    logic               err;

    logic               take;
    logic               w_sel;
    logic               unused_ok;
    logic signed [63:0] op_1_d;
    logic signed [63:0] op_2_d;
    logic               sign_1_d;
    logic               sign_2_d;

    function automatic logic signed [63:0] sext32(input logic [31:0] v);
        logic signed [31:0] s;
        logic signed [63:0] r;
        s = signed'(v);
        r = s;
        return r;
    endfunction

    // MUL returns the low half (or the sign-extended low word for MULW); the rest the high half.
    function automatic logic [63:0] select_result(input logic [1:0] op, input logic w,
                                                  input logic [63:0] res_l,
                                                  input logic [63:0] res_h);
        if (op != 2'd0) return res_h;
        return w ? sext32(res_l[31:0]) : res_l;
    endfunction

`ifdef MUL_W_EN
    assign w_sel     = bus.in_w_i & (bus.in_op_i == 2'd0);
    assign unused_ok = err;
`else
    assign w_sel     = 1'b0;
    assign unused_ok = err ^ bus.in_w_i;
`endif

    assign take = bus.in_valid_i & bus.mul_ready_i & ~bus.kill_i;

    always_comb begin
        op_1_d   = w_sel ? sext32(bus.in_a_i[31:0]) : signed'(bus.in_a_i);
        op_2_d   = w_sel ? sext32(bus.in_b_i[31:0]) : signed'(bus.in_b_i);
        sign_1_d = 1'b0;
        sign_2_d = 1'b0;
        case (bus.in_op_i)
            2'd0:    begin sign_1_d = w_sel; sign_2_d = w_sel; end
            2'd1:    begin sign_1_d = 1'b1;  sign_2_d = 1'b1;  end
            2'd2:    begin sign_1_d = 1'b1;  sign_2_d = 1'b0;  end
            default: begin sign_1_d = 1'b0;  sign_2_d = 1'b0;  end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            op_q        <= 2'd0;
            w_q         <= 1'b0;
            op_1_q      <= '0;
            op_2_q      <= '0;
            sign_1_q    <= 1'b0;
            sign_2_q    <= 1'b0;
            req_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        op_q     <= bus.in_op_i;
                        w_q      <= w_sel;
                        op_1_q   <= op_1_d;
                        op_2_q   <= op_2_d;
                        sign_1_q <= sign_1_d;
                        sign_2_q <= sign_2_d;
                        req_q    <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    req_q <= 1'b0;
                    cnt   <= bus.kill_i ? '0 : CNT_W'(1);
                    state <= bus.kill_i ? IDLE : WAIT;
                end
                WAIT: begin
                    // Valid from the multiplier only counts on the cycle the latency expires.
                    if (bus.kill_i) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (cnt == LAT_C) begin
                        cnt <= '0;
                        if (bus.mul_valid_i) begin
                            out_data_q  <= select_result(op_q, w_q, bus.mul_res_l_i, bus.mul_res_h_i);
                            out_valid_q <= 1'b1;
                            state       <= HOLD;
                        end else begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.out_ready_i | bus.kill_i) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready_o      = (state == IDLE) & bus.mul_ready_i;
    assign bus.mul_block_o     = bus.kill_i & ((state == ISSUE) | (state == WAIT));
    assign bus.mul_req_valid_o = req_q;
    assign bus.mul_op_1_o      = op_1_q;
    assign bus.mul_op_2_o      = op_2_q;
    assign bus.mul_sign_1_o    = sign_1_q;
    assign bus.mul_sign_2_o    = sign_2_q;
    assign bus.out_valid_o     = out_valid_q;
    assign bus.out_data_o      = out_data_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: directed ops against a cycle-phase model plus a behavioural multiplier.
module tb_mul_issue_ctrl;
    localparam int LAT   = 9;
    localparam int CNT_W = 4;
`ifdef MUL_W_EN
    localparam bit W_EN = 1'b1;
`else
    localparam bit W_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    mul_issue_ctrl_if ifc();

    mul_issue_ctrl #(.LAT(LAT), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // controller model: an accepted op lives for a number of phases counted from acceptance
    bit          busy = 1'b0;
    int          kcyc = 0;
    int          acc_cyc = 0;
    logic [1:0]  m_op;
    logic        m_w;
    logic [63:0] m_a, m_b, exp_data;

    // behavioural multiplier
    bit           idle_valid = 1'b0;
    bit           drop_res = 1'b0;
    bit           pend = 1'b0;
    int           mcyc = 0;
    int           rcyc = 0;
    logic [127:0] prod;

    function automatic logic [127:0] ext(input logic s, input logic [63:0] v);
        return s ? {{64{v[63]}}, v} : {64'b0, v};
    endfunction

    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic w,
                                               input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        p = ext(op == 2'd1 || op == 2'd2, a) * ext(op == 2'd1, b);
        if (op != 2'd0) return p[127:64];
        return (W_EN && w) ? {{32{p[31]}}, p[31:0]} : p[63:0];
    endfunction

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int          ph;
        logic        we;
        logic [63:0] e1, e2;
        logic [1:0]  es;
        kcyc++;
        if (rst) busy = 1'b0;
        ph = kcyc - acc_cyc;
        chk1("in_ready", ifc.in_ready_o, !busy && ifc.mul_ready_i);
        chk1("req_valid", ifc.mul_req_valid_o, busy && ph == 1);
        chk1("block", ifc.mul_block_o, busy && ph >= 1 && ph <= LAT + 1 && ifc.kill_i);
        chk1("out_valid", ifc.out_valid_o, busy && ph >= LAT + 2);
        if (busy && ph >= LAT + 2) chk64("out_data", ifc.out_data_o, exp_data);
        if (busy && ph <= LAT + 1) begin
            we = W_EN && m_w && m_op == 2'd0;
            e1 = we ? {{32{m_a[31]}}, m_a[31:0]} : m_a;
            e2 = we ? {{32{m_b[31]}}, m_b[31:0]} : m_b;
            es = (m_op == 2'd1 || we) ? 2'b11 : (m_op == 2'd2) ? 2'b10 : 2'b00;
            chk64("op_1", ifc.mul_op_1_o, e1);
            chk64("op_2", ifc.mul_op_2_o, e2);
            chk64("signs", {62'b0, ifc.mul_sign_1_o, ifc.mul_sign_2_o}, {62'b0, es});
        end
        if (!rst) begin
            if (!busy) begin
                if (ifc.in_valid_i && ifc.mul_ready_i && !ifc.kill_i) begin
                    busy = 1'b1; acc_cyc = kcyc;
                    m_op = ifc.in_op_i; m_w = ifc.in_w_i; m_a = ifc.in_a_i; m_b = ifc.in_b_i;
                    exp_data = ref_result(m_op, m_w, m_a, m_b);
                end
            end else if (ph <= LAT + 1) begin
                if (ifc.kill_i) busy = 1'b0;
                else if (ph == LAT + 1 && !ifc.mul_valid_i) busy = 1'b0;
            end else if (ifc.out_ready_i || ifc.kill_i) begin
                busy = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                            input logic w);
        ifc.in_valid_i = 1'b1; ifc.in_op_i = op; ifc.in_a_i = a; ifc.in_b_i = b; ifc.in_w_i = w;
        cycle();
        ifc.in_valid_i = 1'b0; ifc.in_w_i = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!ifc.out_valid_o && lat < LAT + 6) begin
            cycle();
            lat++;
        end
    endtask

    task automatic release_res();
        ifc.out_ready_i = 1'b1;
        cycle();
        ifc.out_ready_i = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic w, input logic [63:0] lit);
        int lat;
        start_op(op, a, b, w);
        wait_valid(lat);
        chk64({name, "_latency"}, 64'(lat), 64'(LAT + 1));
        chk64(name, ifc.out_data_o, lit);
        release_res();
    endtask

    // behavioural multiplier: result appears exactly LAT cycles after the request cycle
    initial begin
        ifc.mul_valid_i = 1'b0; ifc.mul_res_l_i = '0; ifc.mul_res_h_i = '0;
        forever begin
            @(posedge clk);
            #1;
            mcyc++;
            if (pend && mcyc == rcyc + LAT) begin
                pend = 1'b0;
                ifc.mul_valid_i = !drop_res;
                ifc.mul_res_l_i = prod[63:0];
                ifc.mul_res_h_i = prod[127:64];
            end else begin
                ifc.mul_valid_i = idle_valid;
                ifc.mul_res_l_i = 64'hBADC_0FFE_E0DD_F00D;
                ifc.mul_res_h_i = 64'hDEAD_BEEF_CAFE_F00D;
            end
            @(negedge clk);
            if (rst) pend = 1'b0;
            else if (ifc.mul_req_valid_o) begin
                pend = 1'b1;
                rcyc = mcyc;
                prod = ext(ifc.mul_sign_1_o, ifc.mul_op_1_o) * ext(ifc.mul_sign_2_o, ifc.mul_op_2_o);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [63:0] held;
        rst = 1'b1;
        ifc.in_valid_i = 1'b0; ifc.in_op_i = 2'd0; ifc.in_w_i = 1'b0;
        ifc.in_a_i = '0; ifc.in_b_i = '0; ifc.kill_i = 1'b0;
        ifc.out_ready_i = 1'b0; ifc.mul_ready_i = 1'b1;
        #1;
        chk1("rst_in_ready", ifc.in_ready_o, 1'b1);
        chk1("rst_out_valid", ifc.out_valid_o, 1'b0);
        chk1("rst_req", ifc.mul_req_valid_o, 1'b0);
        chk64("rst_out_data", ifc.out_data_o, 64'h0);
        cycle(); cycle();
        rst = 1'b0;
        cycle();

        // basic function and sign decode
        run_op("mul_3x5", 2'd0, 64'd3, 64'd5, 1'b0, 64'd15);
        run_op("mulh_m1x2", 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("mulhu_m1x2", 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 64'd1);
        run_op("mulhsu_m1x2", 2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("mulh_w_ignored", 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);

        // hold for 20 cycles, then a new op offered in the consuming cycle must wait one cycle
        start_op(2'd0, 64'd7, 64'd6, 1'b0);
        wait_valid(lat);
        held = ifc.out_data_o;
        repeat (20) cycle();
        chk64("hold_data", ifc.out_data_o, 64'd42);
        chk64("hold_stable", ifc.out_data_o, held);
        chk1("hold_in_ready", ifc.in_ready_o, 1'b0);
        ifc.out_ready_i = 1'b1;
        ifc.in_valid_i = 1'b1; ifc.in_op_i = 2'd0; ifc.in_a_i = 64'd2; ifc.in_b_i = 64'd2;
        cycle();
        ifc.out_ready_i = 1'b0;
        chk1("after_hold_in_ready", ifc.in_ready_o, 1'b1);
        chk1("after_hold_out_valid", ifc.out_valid_o, 1'b0);
        run_op("mul_2x2", 2'd0, 64'd2, 64'd2, 1'b0, 64'd4);

        // kill at WAIT counter 4, stale multiplier valid afterwards must be ignored
        start_op(2'd0, 64'd11, 64'd13, 1'b0);
        repeat (4) cycle();
        ifc.kill_i = 1'b1;
        #1;
        chk1("kill_wait_block", ifc.mul_block_o, 1'b1);
        cycle();
        ifc.kill_i = 1'b0;
        #1;
        chk1("kill_wait_block_off", ifc.mul_block_o, 1'b0);
        chk1("kill_wait_idle", ifc.in_ready_o, 1'b1);
        repeat (LAT + 3) cycle();
        chk1("kill_wait_no_result", ifc.out_valid_o, 1'b0);

        // kill in ISSUE
        start_op(2'd3, 64'd5, 64'd5, 1'b0);
        ifc.kill_i = 1'b1;
        #1;
        chk1("kill_issue_block", ifc.mul_block_o, 1'b1);
        cycle();
        ifc.kill_i = 1'b0;
        repeat (LAT + 3) cycle();

        // kill in HOLD drops the result without blocking; kill together with out_ready
        start_op(2'd0, 64'd100, 64'd3, 1'b0);
        wait_valid(lat);
        ifc.kill_i = 1'b1;
        #1;
        chk1("kill_hold_no_block", ifc.mul_block_o, 1'b0);
        cycle();
        ifc.kill_i = 1'b0;
        chk1("kill_hold_dropped", ifc.out_valid_o, 1'b0);
        start_op(2'd0, 64'd8, 64'd8, 1'b0);
        wait_valid(lat);
        chk64("kill_ready_data", ifc.out_data_o, 64'd64);
        ifc.kill_i = 1'b1; ifc.out_ready_i = 1'b1;
        cycle();
        ifc.kill_i = 1'b0; ifc.out_ready_i = 1'b0;
        chk1("kill_ready_idle", ifc.in_ready_o, 1'b1);

        // kill beats in_valid in IDLE; multiplier not ready blocks acceptance
        ifc.in_valid_i = 1'b1; ifc.kill_i = 1'b1;
        cycle(); cycle();
        ifc.in_valid_i = 1'b0; ifc.kill_i = 1'b0;
        chk1("kill_idle_no_req", ifc.mul_req_valid_o, 1'b0);
        ifc.mul_ready_i = 1'b0; ifc.in_valid_i = 1'b1;
        #1;
        chk1("not_ready_in_ready", ifc.in_ready_o, 1'b0);
        cycle(); cycle();
        ifc.in_valid_i = 1'b0; ifc.mul_ready_i = 1'b1;
        chk1("not_ready_no_req", ifc.mul_req_valid_o, 1'b0);

        // multiplier idle valid is ignored, both while idle and before the latency expires
        idle_valid = 1'b1;
        repeat (5) cycle();
        chk1("idle_valid_ignored", ifc.out_valid_o, 1'b0);
        run_op("mul_9x9_idle_valid", 2'd0, 64'd9, 64'd9, 1'b0, 64'd81);
        idle_valid = 1'b0;

        // multiplier never returns valid: back to IDLE, no result
        drop_res = 1'b1;
        start_op(2'd0, 64'd4, 64'd4, 1'b0);
        repeat (LAT + 4) cycle();
        drop_res = 1'b0;
        chk1("missing_valid_no_result", ifc.out_valid_o, 1'b0);
        chk1("missing_valid_idle", ifc.in_ready_o, 1'b1);

        // asynchronous reset in the middle of WAIT
        start_op(2'd1, 64'd12345, 64'd678, 1'b0);
        repeat (3) cycle();
        rst = 1'b1;
        #1;
        chk1("rst_wait_in_ready", ifc.in_ready_o, 1'b1);
        chk1("rst_wait_req", ifc.mul_req_valid_o, 1'b0);
        chk1("rst_wait_out_valid", ifc.out_valid_o, 1'b0);
        chk64("rst_wait_op_1", ifc.mul_op_1_o, 64'h0);
        chk64("rst_wait_op_2", ifc.mul_op_2_o, 64'h0);
        cycle(); cycle();
        rst = 1'b0;
        cycle();
        run_op("mul_after_rst", 2'd0, 64'd6, 64'd7, 1'b0, 64'd42);

        // word multiply
        run_op("mulw_8000_0000x2", 2'd0, 64'h0000_0000_8000_0000, 64'd2, 1'b1,
               W_EN ? 64'h0 : 64'h0000_0001_0000_0000);
        run_op("mulw_4000_0000x2", 2'd0, 64'h0000_0000_4000_0000, 64'd2, 1'b1,
               W_EN ? 64'hFFFF_FFFF_8000_0000 : 64'h0000_0000_8000_0000);
        repeat (3) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
